// File: rtl/simplebus_arbiter_pkg.sv
// Shared types for the Simplebus arbiter: FSM state and the per-requester command buffer.
package simplebus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_WR,
    WAIT_RD
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_write;
  } cmd_t;

endpackage

// File: rtl/simplebus_arbiter_if.sv
// Simplebus downstream port: the arbiter drives the master side, the slave answers.
interface simplebus_arbiter_if;
  import simplebus_arbiter_pkg::*;

  logic [ADDR_W-1:0] sb_address;
  logic [DATA_W-1:0] sb_write_data;
  logic              sb_read_strobe;
  logic              sb_write_strobe;
  logic [DATA_W-1:0] sb_read_data;
  logic              sb_read_valid;
  logic              sb_ready;

  modport master (
    output sb_address, sb_write_data, sb_read_strobe, sb_write_strobe,
    input  sb_read_data, sb_read_valid, sb_ready
  );

  modport slave (
    input  sb_address, sb_write_data, sb_read_strobe, sb_write_strobe,
    output sb_read_data, sb_read_valid, sb_ready
  );

endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin picker: searches from pointer+1 upward (wrapping) and remembers the last grant.
module round_robin_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant_c,
  output logic [IW-1:0] o_index_c,
  output logic          o_valid_c
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;

  // First requester after the pointer wins; the pointer itself is checked last.
  always_comb begin
    o_grant_c = '0;
    o_index_c = '0;
    o_valid_c = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(r_ptr) + k) % N);
      if (!o_valid_c && i_req[w_cand]) begin
        o_valid_c         = 1'b1;
        o_index_c         = w_cand;
        o_grant_c[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_enable && o_valid_c) begin
      r_ptr <= o_index_c;
    end
  end

endmodule

// File: rtl/simplebus_arbiter.sv
// Shares one Simplebus slave between N_MASTERS requesters, one command in flight at a time,
// with a one-entry buffer per requester and a read timeout.
module simplebus_arbiter
  import simplebus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_MASTERS*32-1:0] m_address,
  input  logic [N_MASTERS*32-1:0] m_write_data,
  input  logic [N_MASTERS-1:0]    m_read_strobe,
  input  logic [N_MASTERS-1:0]    m_write_strobe,
  output logic [N_MASTERS-1:0]    m_ready,
  output logic [N_MASTERS-1:0]    m_read_valid,
  output logic [31:0]             m_read_data,
  output logic [N_MASTERS-1:0]    timeout_error,
  simplebus_arbiter_if.master     slave_bus
);

  localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                r_state;
  cmd_t                  r_buf [N_MASTERS];
  logic [N_MASTERS-1:0]  r_full;
  logic [N_MASTERS-1:0]  r_ready;
  logic [N_MASTERS-1:0]  r_rvalid;
  logic [N_MASTERS-1:0]  r_terr;
  logic [DATA_W-1:0]     r_rdata;
  logic [ADDR_W-1:0]     r_sb_addr;
  logic [DATA_W-1:0]     r_sb_wdata;
  logic                  r_sb_rs;
  logic                  r_sb_ws;
  logic [IW-1:0]         r_owner;
  logic                  r_op_write;
  logic [TW-1:0]         r_tcnt;

  logic [N_MASTERS-1:0]  w_capture;
  logic [N_MASTERS-1:0]  w_grant;
  logic [IW-1:0]         w_gidx;
  logic                  w_gvalid;
  logic                  w_issue;
  cmd_t                  w_sel;

  assign w_capture = r_ready & (m_read_strobe | m_write_strobe);
  assign w_issue   = (r_state == IDLE) && w_gvalid && slave_bus.sb_ready;

  round_robin_arbiter #(.N(N_MASTERS)) u_rr (
    .clk       (clock),
    .rst       (reset),
    .i_req     (r_full),
    .i_enable  (w_issue),
    .o_grant_c (w_grant),
    .o_index_c (w_gidx),
    .o_valid_c (w_gvalid)
  );

  // One-hot mux of the winning buffer.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (w_grant[i]) w_sel = r_buf[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_full     <= '0;
      r_ready    <= '1;
      r_rvalid   <= '0;
      r_terr     <= '0;
      r_rdata    <= '0;
      r_sb_addr  <= '0;
      r_sb_wdata <= '0;
      r_sb_rs    <= 1'b0;
      r_sb_ws    <= 1'b0;
      r_owner    <= '0;
      r_op_write <= 1'b0;
      r_tcnt     <= '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) r_buf[i] <= '0;
    end else begin
      r_rvalid <= '0;
      r_terr   <= '0;
      r_sb_rs  <= 1'b0;
      r_sb_ws  <= 1'b0;

      // Ready re-arms one cycle after the buffer has been freed.
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (w_capture[i]) begin
          r_buf[i].addr     <= m_address[32*i +: 32];
          r_buf[i].data     <= m_write_data[32*i +: 32];
          r_buf[i].is_write <= m_write_strobe[i];
          r_full[i]         <= 1'b1;
          r_ready[i]        <= 1'b0;
        end else if (!r_ready[i] && !r_full[i]) begin
          r_ready[i] <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_owner    <= w_gidx;
            r_op_write <= w_sel.is_write;
            r_sb_addr  <= w_sel.addr;
            r_sb_wdata <= w_sel.data;
            r_sb_ws    <= w_sel.is_write;
            r_sb_rs    <= !w_sel.is_write;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_tcnt  <= '0;
          r_state <= r_op_write ? WAIT_WR : WAIT_RD;
        end
        WAIT_WR: begin
          if (slave_bus.sb_ready) begin
            r_full[r_owner] <= 1'b0;
            r_state         <= IDLE;
          end
        end
        WAIT_RD: begin
          if (slave_bus.sb_read_valid) begin
            r_rdata           <= slave_bus.sb_read_data;
            r_rvalid[r_owner] <= 1'b1;
            r_full[r_owner]   <= 1'b0;
            r_state           <= IDLE;
          end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_rdata           <= TIMEOUT_DATA;
            r_rvalid[r_owner] <= 1'b1;
            r_terr[r_owner]   <= 1'b1;
            r_full[r_owner]   <= 1'b0;
            r_state           <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_ready                   = r_ready;
  assign m_read_valid              = r_rvalid;
  assign m_read_data               = r_rdata;
  assign timeout_error             = r_terr;
  assign slave_bus.sb_address      = r_sb_addr;
  assign slave_bus.sb_write_data   = r_sb_wdata;
  assign slave_bus.sb_read_strobe  = r_sb_rs;
  assign slave_bus.sb_write_strobe = r_sb_ws;

endmodule

// File: tb/tb_simplebus_arbiter.sv
// Bench for simplebus_arbiter: directed scenarios plus a randomized run against a round-robin model.
module tb_simplebus_arbiter;

  localparam int          N       = 4;
  localparam int          TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
  localparam int          RUN     = 1500;

  logic            clock;
  logic            reset;
  logic [N*32-1:0] m_address;
  logic [N*32-1:0] m_write_data;
  logic [N-1:0]    m_read_strobe;
  logic [N-1:0]    m_write_strobe;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    m_read_valid;
  logic [31:0]     m_read_data;
  logic [N-1:0]    timeout_error;

  int n_checks = 0;
  int n_fail   = 0;

  simplebus_arbiter_if sb ();

  simplebus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TO_DATA)) dut (
    .clock          (clock),
    .reset          (reset),
    .m_address      (m_address),
    .m_write_data   (m_write_data),
    .m_read_strobe  (m_read_strobe),
    .m_write_strobe (m_write_strobe),
    .m_ready        (m_ready),
    .m_read_valid   (m_read_valid),
    .m_read_data    (m_read_data),
    .timeout_error  (timeout_error),
    .slave_bus      (sb)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic idle_inputs();
    m_read_strobe  = '0;
    m_write_strobe = '0;
  endtask

  task automatic drive_cmd(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    m_address[32*i +: 32]    = a;
    m_write_data[32*i +: 32] = d;
    if (wr) m_write_strobe[i] = 1'b1;
    else    m_read_strobe[i]  = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    sb.sb_ready = 1'b1; sb.sb_read_valid = 1'b0; sb.sb_read_data = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    m_address = '0; m_write_data = '0;
    sb.sb_ready = 1'b1; sb.sb_read_valid = 1'b0; sb.sb_read_data = '0;
    repeat (2) @(negedge clock);
    n_checks++; if (m_ready !== 4'hF) begin n_fail++; $display("FAIL reset_m_ready got %h want f", m_ready); end
    n_checks++; if (m_read_valid !== 4'h0) begin n_fail++; $display("FAIL reset_read_valid got %h want 0", m_read_valid); end
    n_checks++; if (m_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data got %h want 0", m_read_data); end
    n_checks++; if (timeout_error !== 4'h0) begin n_fail++; $display("FAIL reset_timeout got %h want 0", timeout_error); end
    n_checks++; if (sb.sb_address !== 32'h0) begin n_fail++; $display("FAIL reset_sb_address got %h want 0", sb.sb_address); end
    n_checks++; if (sb.sb_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_sb_wdata got %h want 0", sb.sb_write_data); end
    n_checks++; if ({sb.sb_read_strobe, sb.sb_write_strobe} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sb_strobes got %b want 00", {sb.sb_read_strobe, sb.sb_write_strobe}); end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    int ws_cnt = 0;
    @(negedge clock);
    sb.sb_ready = 1'b1;
    drive_cmd(0, 1'b1, 32'h10, 32'hA5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) idle_inputs();
      if (sb.sb_write_strobe === 1'b1) ws_cnt++;
      n_checks++; if (sb.sb_write_strobe !== (k == 2)) begin
        n_fail++; $display("FAIL write_strobe cycle %0d got %b want %b", k, sb.sb_write_strobe, (k == 2)); end
      n_checks++; if (m_ready[0] !== (k >= 5)) begin
        n_fail++; $display("FAIL write_m_ready cycle %0d got %b want %b", k, m_ready[0], (k >= 5)); end
      if (k == 2) begin
        n_checks++; if (sb.sb_address !== 32'h10) begin n_fail++; $display("FAIL write_addr got %h want 10", sb.sb_address); end
        n_checks++; if (sb.sb_write_data !== 32'hA5) begin n_fail++; $display("FAIL write_data got %h want a5", sb.sb_write_data); end
      end
    end
    n_checks++; if (ws_cnt != 1) begin n_fail++; $display("FAIL write_pulse_count got %0d want 1", ws_cnt); end
  endtask

  task automatic test_single_read();
    @(negedge clock);
    drive_cmd(2, 1'b0, 32'h20, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) idle_inputs();
      n_checks++; if (sb.sb_read_strobe !== (k == 2)) begin
        n_fail++; $display("FAIL read_strobe cycle %0d got %b want %b", k, sb.sb_read_strobe, (k == 2)); end
      if (k == 2) begin
        n_checks++; if (sb.sb_address !== 32'h20) begin n_fail++; $display("FAIL read_addr got %h want 20", sb.sb_address); end
      end
      n_checks++; if (m_read_valid !== ((k == 6) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL read_valid cycle %0d got %b", k, m_read_valid); end
      n_checks++; if (timeout_error !== 4'b0000) begin n_fail++; $display("FAIL read_timeout cycle %0d got %b want 0000", k, timeout_error); end
      if (k == 6) begin
        n_checks++; if (m_read_data !== 32'h1234) begin n_fail++; $display("FAIL read_data got %h want 1234", m_read_data); end
      end
      n_checks++; if (m_ready[2] !== (k == 7)) begin n_fail++; $display("FAIL read_m_ready cycle %0d got %b", k, m_ready[2]); end
      sb.sb_read_valid = (k == 5);
      sb.sb_read_data  = (k == 5) ? 32'h1234 : 32'h0;
    end
  endtask

  task automatic test_contention();
    logic [31:0] seen_a[$];
    logic [31:0] seen_d[$];
    int exp_order[4] = '{1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) drive_cmd(i, 1'b1, 32'h100 + 32'(i), 32'hC0 + 32'(i));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) idle_inputs();
      if (sb.sb_write_strobe === 1'b1) begin seen_a.push_back(sb.sb_address); seen_d.push_back(sb.sb_write_data); end
    end
    n_checks++; if (seen_a.size() != 4) begin n_fail++; $display("FAIL contention_count got %0d want 4", seen_a.size()); end
    for (int j = 0; j < 4; j++) begin
      if (seen_a.size() > j) begin
        n_checks++; if (seen_a[j] !== 32'h100 + 32'(exp_order[j])) begin
          n_fail++; $display("FAIL contention_order slot %0d got %h want %h", j, seen_a[j], 32'h100 + 32'(exp_order[j])); end
        n_checks++; if (seen_d[j] !== 32'hC0 + 32'(exp_order[j])) begin
          n_fail++; $display("FAIL contention_data slot %0d got %h want %h", j, seen_d[j], 32'hC0 + 32'(exp_order[j])); end
      end
    end
    n_checks++; if (m_ready !== 4'hF) begin n_fail++; $display("FAIL contention_ready got %h want f", m_ready); end
  endtask

  task automatic test_timeout();
    @(negedge clock);
    drive_cmd(1, 1'b0, 32'h30, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) idle_inputs();
      n_checks++; if (m_read_valid !== ((k == 11) ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL timeout_valid cycle %0d got %b", k, m_read_valid); end
      n_checks++; if (timeout_error !== ((k == 11) ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL timeout_error cycle %0d got %b", k, timeout_error); end
      if (k == 11) begin
        n_checks++; if (m_read_data !== TO_DATA) begin n_fail++; $display("FAIL timeout_data got %h want %h", m_read_data, TO_DATA); end
      end
    end
    n_checks++; if (m_ready[1] !== 1'b1) begin n_fail++; $display("FAIL timeout_ready got %b want 1", m_ready[1]); end
  endtask

  task automatic test_backpressure();
    int extra = 0;
    @(negedge clock);
    sb.sb_ready = 1'b0;
    drive_cmd(3, 1'b1, 32'h40, 32'h77);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (k == 1 || k == 4) idle_inputs();
      if (k == 3) drive_cmd(3, 1'b0, 32'h99, 32'h0);
      n_checks++; if ({sb.sb_write_strobe, sb.sb_read_strobe} !== ((k == 11) ? 2'b10 : 2'b00)) begin
        n_fail++; $display("FAIL bp_strobes cycle %0d got %b", k, {sb.sb_write_strobe, sb.sb_read_strobe}); end
      if (k == 11) begin
        n_checks++; if (sb.sb_address !== 32'h40) begin n_fail++; $display("FAIL bp_addr got %h want 40", sb.sb_address); end
        n_checks++; if (sb.sb_write_data !== 32'h77) begin n_fail++; $display("FAIL bp_data got %h want 77", sb.sb_write_data); end
      end else begin
        n_checks++; if (m_ready[3] !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d got %b want 0", k, m_ready[3]); end
      end
      if (k == 10) sb.sb_ready = 1'b1;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (sb.sb_write_strobe === 1'b1 || sb.sb_read_strobe === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL bp_ignored_strobe got %0d extra issues want 0", extra); end
    n_checks++; if (m_ready[3] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_final got %b want 1", m_ready[3]); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clock);
    drive_cmd(0, 1'b0, 32'h50, 32'h0);
    repeat (4) begin @(negedge clock); idle_inputs(); end
    reset = 1'b1;
    #1;
    n_checks++; if (m_ready !== 4'hF) begin n_fail++; $display("FAIL midrst_ready got %h want f", m_ready); end
    n_checks++; if (m_read_data !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got %h want 0", m_read_data); end
    n_checks++; if (sb.sb_address !== 32'h0) begin n_fail++; $display("FAIL midrst_sb_addr got %h want 0", sb.sb_address); end
    n_checks++; if ({m_read_valid, timeout_error} !== 8'h00) begin
      n_fail++; $display("FAIL midrst_pulses got %h want 00", {m_read_valid, timeout_error}); end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sb.sb_read_valid = (k < 3);
      sb.sb_read_data  = 32'hBAD0 + 32'(k);
      @(negedge clock);
      n_checks++; if (m_read_valid !== 4'h0) begin n_fail++; $display("FAIL midrst_no_valid step %0d got %b", k, m_read_valid); end
    end
    sb.sb_read_valid = 1'b0;
    drive_cmd(1, 1'b1, 32'h60, 32'h61);
    @(negedge clock); idle_inputs();
    n_checks++; if (sb.sb_write_strobe !== 1'b0) begin n_fail++; $display("FAIL midrst_early_strobe got %b want 0", sb.sb_write_strobe); end
    @(negedge clock);
    n_checks++; if (sb.sb_write_strobe !== 1'b1 || sb.sb_address !== 32'h60) begin
      n_fail++; $display("FAIL midrst_next_req got ws=%b addr=%h want ws=1 addr=60", sb.sb_write_strobe, sb.sb_address); end
    repeat (4) @(negedge clock);
  endtask

  // Model: pending commands, the last granted index, and a slave that answers reads after a random delay.
  task automatic test_random();
    bit pend[N]; bit p_wr[N]; logic [31:0] p_addr[N]; logic [31:0] p_data[N];
    bit stg[N];  bit s_wr[N]; logic [31:0] s_addr[N]; logic [31:0] s_data[N];
    int last = 0; int captured = 0; int issued = 0;
    bit rd_busy = 0; int rd_cnt = 0; int rd_owner = 0; logic [31:0] rd_addr = '0;
    logic [N-1:0] exp_rv = '0; logic [31:0] exp_rdata = '0;
    bit drained = 0;
    apply_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 0; stg[i] = 0; end
    for (int cyc = 0; cyc < RUN + 300 && !drained; cyc++) begin
      bit just_issued = 0;
      bool_any: begin end
      @(negedge clock);
      n_checks++; if (m_read_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_read_valid cyc %0d got %b want %b", cyc, m_read_valid, exp_rv); end
      if (exp_rv != '0) begin
        n_checks++; if (m_read_data !== exp_rdata) begin n_fail++; $display("FAIL rnd_read_data cyc %0d got %h want %h", cyc, m_read_data, exp_rdata); end
      end
      n_checks++; if (timeout_error !== '0) begin n_fail++; $display("FAIL rnd_timeout cyc %0d got %b want 0", cyc, timeout_error); end
      exp_rv = '0;
      if (sb.sb_write_strobe === 1'b1 || sb.sb_read_strobe === 1'b1) begin
        int w = -1;
        for (int k = 1; k <= N; k++) if (w < 0 && pend[(last + k) % N]) w = (last + k) % N;
        n_checks++;
        if (w < 0) begin
          n_fail++; $display("FAIL rnd_spurious_issue cyc %0d addr %h", cyc, sb.sb_address);
        end else if (sb.sb_address !== p_addr[w] || sb.sb_write_strobe !== p_wr[w] || sb.sb_read_strobe !== !p_wr[w]
                     || (p_wr[w] && sb.sb_write_data !== p_data[w])) begin
          n_fail++; $display("FAIL rnd_issue cyc %0d got addr=%h ws=%b rs=%b wd=%h want m%0d addr=%h wr=%b wd=%h",
                             cyc, sb.sb_address, sb.sb_write_strobe, sb.sb_read_strobe, sb.sb_write_data,
                             w, p_addr[w], p_wr[w], p_data[w]);
        end
        if (w >= 0) begin
          pend[w] = 0; last = w; issued++;
          if (!p_wr[w]) begin rd_busy = 1; just_issued = 1; rd_cnt = int'($urandom_range(0, 5)); rd_owner = w; rd_addr = p_addr[w]; end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (stg[i]) begin pend[i] = 1; p_wr[i] = s_wr[i]; p_addr[i] = s_addr[i]; p_data[i] = s_data[i]; stg[i] = 0; captured++; end
        if (pend[i]) begin
          n_checks++; if (m_ready[i] !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_busy cyc %0d m%0d got %b want 0", cyc, i, m_ready[i]); end
        end
      end
      sb.sb_ready = ($urandom_range(0, 3) != 0);
      if (rd_busy && !just_issued) begin
        if (rd_cnt == 0) begin
          sb.sb_read_valid = 1'b1; sb.sb_read_data = {rd_addr[15:0], ~rd_addr[15:0]};
          exp_rv = '0; exp_rv[rd_owner] = 1'b1; exp_rdata = {rd_addr[15:0], ~rd_addr[15:0]}; rd_busy = 0;
        end else begin
          sb.sb_read_valid = 1'b0; rd_cnt--;
        end
      end else if (!rd_busy) begin
        sb.sb_read_valid = ($urandom_range(0, 7) == 0); sb.sb_read_data = $urandom;
      end else begin
        sb.sb_read_valid = 1'b0;
      end
      idle_inputs();
      if (cyc < RUN) begin
        for (int i = 0; i < N; i++) begin
          if (m_ready[i] === 1'b1 && $urandom_range(0, 2) == 0) begin
            int op = int'($urandom_range(0, 2));
            s_addr[i] = $urandom; s_data[i] = $urandom; s_wr[i] = (op != 0); stg[i] = 1;
            m_address[32*i +: 32] = s_addr[i]; m_write_data[32*i +: 32] = s_data[i];
            if (op != 1) m_read_strobe[i] = 1'b1;
            if (op != 0) m_write_strobe[i] = 1'b1;
          end
        end
      end else if (!rd_busy && exp_rv == '0 && issued == captured && m_ready === 4'hF) begin
        drained = 1;
      end
    end
    sb.sb_read_valid = 1'b0; sb.sb_ready = 1'b1;
    n_checks++; if (!drained || issued != captured) begin
      n_fail++; $display("FAIL rnd_drain drained=%0d issued=%0d captured=%0d", drained, issued, captured); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simplebus_arbiter.md
Name: simplebus_arbiter

Overview:
- Shares one Simplebus slave between N_MASTERS requesters, such as the control processor, a debug bridge and proxy-write engines.
- Each requester gets a one-entry command buffer.
- A round-robin scheduler issues buffered commands to the slave one at a time and routes read data back to the owner.
- A read timeout guards against slaves that never return data.

Parameters:
- N_MASTERS, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, cycles to wait for sb_read_valid before aborting a read.
- TIMEOUT_DATA, 32'hDEAD_BEEF, data returned to the requester on a timed-out read.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset (async, active-high).
- m_address  in  N_MASTERS*32  per-requester address; slice i = [32*i +: 32].
- m_write_data  in  N_MASTERS*32  per-requester write data.
- m_read_strobe  in  N_MASTERS  per-requester read request, single-cycle pulse.
- m_write_strobe  in  N_MASTERS  per-requester write request, single-cycle pulse.
- m_ready  out  N_MASTERS  requester i may issue a strobe (its buffer is empty).
- m_read_valid  out  N_MASTERS  one-hot, single-cycle read-return pulse.
- m_read_data  out  32  shared read data, qualified by m_read_valid.
- timeout_error  out  N_MASTERS  one-cycle pulse to the owner of an aborted read.
- slave_bus  Simplebus.master  -  downstream bus: sb_address, sb_read_strobe, sb_write_strobe, sb_write_data, sb_read_data, sb_read_valid, sb_ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - m_ready all 1, m_read_valid 0, m_read_data 0, timeout_error 0.
  - sb_address, sb_write_data, sb_read_strobe and sb_write_strobe all 0.
  - All buffers empty; RR pointer 0; state IDLE.
- Capture:
  - A strobe on i while m_ready[i]=1 latches {address, data, is_write} into buffer i on that edge.
  - m_ready[i] drops the next cycle.
  - A strobe while m_ready[i]=0 is ignored.
  - Read and write strobes together on one cycle count as a write (write wins).
- Scheduler:
  - Round-robin over full buffers, starting at pointer+1 (wrapping modulo N_MASTERS).
  - The pointer updates to the granted index at issue.
- FSM:
  - IDLE: if any buffer is full and sb_ready=1, grant the winner, drive address/data with the matching strobe for exactly one cycle, go to ISSUE.
  - ISSUE: strobe low, go to WAIT_WR or WAIT_RD. The slave is allowed to keep sb_ready high in this cycle.
  - WAIT_WR: on the first cycle with sb_ready=1 the write completes; free the buffer, go to IDLE. This gives a minimum write occupancy of 3 cycles.
  - WAIT_RD:
    - On sb_read_valid=1: register sb_read_data into m_read_data and pulse m_read_valid[owner] on the next cycle; free the buffer; go to IDLE.
    - Timeout counter runs 0..TIMEOUT_CYCLES-1. On expiry, return TIMEOUT_DATA with m_read_valid[owner] and timeout_error[owner] together, free the buffer, go to IDLE.
- Buffer release:
  - m_ready[owner] reasserts the cycle after completion.
  - A new strobe from that requester is accepted from then on.
- Simultaneous events:
  - A capture on requester j during the owner's completion cycle is legal; j competes in the next IDLE arbitration.
  - Freed buffer i cannot be re-granted before the pointer has passed it, which guarantees fairness.
- Stray slave signals: sb_read_valid outside WAIT_RD is ignored.
- Reset mid-transaction: all buffers and the FSM clear asynchronously. Pending commands are lost silently; no read_valid is generated.
- Throughput: one transaction in flight at a time. Latency from strobe to slave strobe is 2 cycles when uncontended (capture edge, then IDLE issue edge).

Decomposition:
- Package simplebus_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_WR, WAIT_RD);
  - the command-buffer struct {addr[31:0], data[31:0], is_write}.
- Sub-module round_robin_arbiter (parameter N):
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant, granted index, grant_valid.
  - Combinational rotate/priority logic plus a registered pointer, updated when enable is high.

Test Plan:
1. Single write: m0 writes addr 0x10 data 0xA5 with the slave holding sb_ready=1 -> sb_write_strobe one cycle, 2 cycles after the strobe, with 0x10/0xA5; m_ready[0] low for 4 cycles.
2. Single read: m2 reads 0x20 and the slave returns 0x1234 after 3 cycles -> m_read_valid=4'b0100 with m_read_data=0x1234; no timeout_error.
3. Contention: all four requesters strobe writes in the same cycle -> slave sees addresses in the order m1, m2, m3, m0 (pointer starts at 0), each strobed exactly once.
4. Timeout: TIMEOUT_CYCLES=8 and the slave never asserts read_valid on m1's read -> after 8 WAIT_RD cycles, m_read_valid[1] and timeout_error[1] pulse with data 0xDEADBEEF; m_ready[1] returns to 1.
5. Backpressure and ignored strobe:
   - Slave holds sb_ready=0 for 10 cycles with m3's command buffered -> no slave strobe until sb_ready=1.
   - A second m3 strobe during this window is ignored.
6. Reset mid-read: assert reset in WAIT_RD -> all outputs return to reset values immediately; no m_read_valid after release; the next request proceeds normally.
